// File: rtl/soc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// soc_mem_arbiter: round-robin share of one memory port between instr/data
// Revision: 1.0
// ============================================================================
module soc_mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,
  output logic                instr_err_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_err_i,
  output logic                proto_err_o
);

  localparam int c_BE_W  = DATA_W / 8;
  localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_OUTSTANDING);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  owner_e               r_fifo [MAX_OUTSTANDING];
  logic [c_PTR_W-1:0]   r_wptr;
  logic [c_PTR_W-1:0]   r_rptr;
  logic [c_CNT_W-1:0]   r_count;
  owner_e               r_last_grant;
  logic                 r_lock;
  owner_e               r_lock_sel;
  logic                 r_proto_err;

  logic   w_full;
  logic   w_empty;
  owner_e w_sel;
  logic   w_hs;
  logic   w_push;
  logic   w_pop;
  owner_e w_head;

  assign w_full  = (r_count == c_MAX_CNT);
  assign w_empty = (r_count == '0);

  // A stalled address phase keeps its owner until accepted, so the
  // address seen by memory never changes under a pending request.
  always_comb begin
    w_sel = OWNER_INSTR;
    if (r_lock) begin
      w_sel = r_lock_sel;
    end else if (instr_req_i && data_req_i) begin
      w_sel = (r_last_grant == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
    end else if (data_req_i) begin
      w_sel = OWNER_DATA;
    end
  end

  assign mem_req_o = ~rst & (instr_req_i | data_req_i) & ~w_full;
  assign w_hs      = mem_req_o & mem_gnt_i;
  assign w_push    = w_hs;
  assign w_pop     = mem_rvalid_i & ~w_empty;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = {c_BE_W{1'b1}};
    mem_addr_o  = instr_addr_i;
    mem_wdata_o = '0;
    if (w_sel == OWNER_DATA) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  assign instr_gnt_o = w_hs & (w_sel == OWNER_INSTR);
  assign data_gnt_o  = w_hs & (w_sel == OWNER_DATA);

  always_comb begin
    w_head = OWNER_INSTR;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (r_rptr == c_PTR_W'(i)) begin
        w_head = r_fifo[i];
      end
    end
  end

  assign instr_rvalid_o = w_pop & (w_head == OWNER_INSTR);
  assign data_rvalid_o  = w_pop & (w_head == OWNER_DATA);
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_err_o     = data_rvalid_o & mem_err_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign proto_err_o    = r_proto_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_fifo[i] <= OWNER_INSTR;
      end
    end else if (w_push) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (r_wptr == c_PTR_W'(i)) begin
          r_fifo[i] <= w_sel;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == c_LAST_PTR) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_LAST_PTR) ? '0 : r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // last_grant resets to data so the instruction side wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= OWNER_DATA;
      r_lock       <= 1'b0;
      r_lock_sel   <= OWNER_INSTR;
      r_proto_err  <= 1'b0;
    end else begin
      if (w_hs) begin
        r_last_grant <= w_sel;
        r_lock       <= 1'b0;
      end else if (mem_req_o) begin
        r_lock     <= 1'b1;
        r_lock_sel <= w_sel;
      end
      if (mem_rvalid_i && w_empty) begin
        r_proto_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
